// File: rtl/seq_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seq_pkg : shared frame geometry, loader state encoding, frame fields      |
// | Rev 1.0                                                                    |
// +--------------------------------------------------------------------------+
package seq_pkg;

  localparam int FRAME_WORDS = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_VALID = 2'd2
  } seq_state_e;

  // Frame layout as consumed by the sequencer engine (word index within frame)
  localparam int FRM_REPEATS_WORD = 0;
  localparam int FRM_INMASK_WORD  = 1;
  localparam int FRM_PHASE1_WORD  = 2;
  localparam int FRM_PHASE2_WORD  = 3;
  localparam int FRM_INPUTS_LSB   = 0;
  localparam int FRM_MASK_LSB     = 16;

  function automatic int frame_word_lsb(input int word);
    return word * 32;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_table_ram.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seq_table_ram : simple dual-port table RAM, registered read (BRAM)        |
// | Rev 1.0                                                                    |
// +--------------------------------------------------------------------------+
module seq_table_ram #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rdata;

  // No reset on the array or read register so the tools map this onto BRAM
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/seq_table_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seq_table_loader : register-fed table store and frame prefetcher          |
// | Rev 1.0                                                                    |
// +--------------------------------------------------------------------------+
module seq_table_loader #(
  parameter int FRAME_WORDS = seq_pkg::FRAME_WORDS,
  parameter int DEPTH       = 1024,
  parameter int AW          = 10
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      trst_i,
  input  logic [31:0]               tdat_i,
  input  logic                      tdat_wstb_i,
  input  logic [15:0]               tlen_i,
  input  logic                      tlen_wstb_i,
  input  logic                      start_i,
  input  logic                      next_i,
  output logic [32*FRAME_WORDS-1:0] frame_o,
  output logic                      frame_valid_o,
  output logic [15:0]               frame_idx_o,
  output logic                      last_frame_o,
  output logic                      table_ready_o,
  output logic [AW:0]               wr_words_o,
  output logic                      err_o
);
  import seq_pkg::*;

  localparam int SW = $clog2(FRAME_WORDS);
  localparam int CW = SW + 1;

  seq_state_e               r_state;
  logic [AW:0]              r_wr_ptr;
  logic                     r_err;
  logic                     r_ready;
  logic [15:0]              r_nframes;
  logic [15:0]              r_idx;
  logic [AW-1:0]            r_base;
  logic [CW-1:0]            r_rd_cnt;
  logic                     r_rd_vld;
  logic [SW-1:0]            r_rd_slot;
  logic [32*FRAME_WORDS-1:0] r_frame;
  logic                     r_frame_valid;
  logic                     r_last;

  logic        w_full;
  logic        w_wr_en;
  logic        w_wr_drop;
  logic [AW:0] w_wr_ptr_nxt;
  logic        w_len_ok;
  logic        w_rd_en;
  logic        w_at_last;
  logic [31:0] w_rd_data;

  assign w_full       = (r_wr_ptr == (AW+1)'(DEPTH));
  assign w_wr_en      = tdat_wstb_i & ~trst_i & ~r_ready & ~w_full;
  assign w_wr_drop    = tdat_wstb_i & ~trst_i & (r_ready | w_full);
  assign w_wr_ptr_nxt = r_wr_ptr + (AW+1)'(w_wr_en);
  // Same-cycle TDAT+TLEN: length is judged against the post-write count
  assign w_len_ok     = (tlen_i != 16'd0) &&
                        ((tlen_i % 16'(FRAME_WORDS)) == 16'd0) &&
                        (32'(tlen_i) <= 32'(w_wr_ptr_nxt));
  assign w_rd_en      = (r_state == ST_FETCH) && (r_rd_cnt < CW'(FRAME_WORDS));
  assign w_at_last    = (r_idx == r_nframes - 16'd1);

  seq_table_ram #(.DEPTH(DEPTH), .AW(AW), .DW(32)) u_ram (
    .clk     (clk_i),
    .i_we    (w_wr_en),
    .i_waddr (r_wr_ptr[AW-1:0]),
    .i_wdata (tdat_i),
    .i_re    (w_rd_en),
    .i_raddr (r_base + AW'(r_rd_cnt)),
    .o_rdata (w_rd_data)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i || trst_i) begin
      r_state       <= ST_IDLE;
      r_wr_ptr      <= '0;
      r_err         <= 1'b0;
      r_ready       <= 1'b0;
      r_nframes     <= '0;
      r_idx         <= '0;
      r_base        <= '0;
      r_rd_cnt      <= '0;
      r_rd_vld      <= 1'b0;
      r_rd_slot     <= '0;
      r_frame       <= '0;
      r_frame_valid <= 1'b0;
      r_last        <= 1'b0;
    end else begin
      r_wr_ptr  <= w_wr_ptr_nxt;
      r_rd_vld  <= w_rd_en;
      r_rd_slot <= r_rd_cnt[SW-1:0];
      if (w_wr_drop) r_err <= 1'b1;
      if (r_rd_vld) r_frame[32*r_rd_slot +: 32] <= w_rd_data;

      if (tlen_wstb_i && !w_len_ok) begin
        r_err         <= 1'b1;
        r_ready       <= 1'b0;
        r_state       <= ST_IDLE;
        r_rd_cnt      <= '0;
        r_frame_valid <= 1'b0;
        r_last        <= 1'b0;
      end else begin
        if (tlen_wstb_i) begin
          r_ready   <= 1'b1;
          r_nframes <= tlen_i / 16'(FRAME_WORDS);
        end
        case (r_state)
          ST_IDLE: begin
            if (start_i && r_ready) begin
              r_state  <= ST_FETCH;
              r_idx    <= '0;
              r_base   <= '0;
              r_rd_cnt <= '0;
            end
          end
          ST_FETCH: begin
            if (w_rd_en) r_rd_cnt <= r_rd_cnt + CW'(1);
            if (r_rd_vld && (r_rd_slot == SW'(FRAME_WORDS - 1))) begin
              r_state       <= ST_VALID;
              r_frame_valid <= 1'b1;
              r_last        <= w_at_last;
            end
          end
          ST_VALID: begin
            if (start_i || next_i) begin
              r_state       <= ST_FETCH;
              r_rd_cnt      <= '0;
              r_frame_valid <= 1'b0;
              r_last        <= 1'b0;
              if (start_i || w_at_last) begin
                r_idx  <= '0;
                r_base <= '0;
              end else begin
                r_idx  <= r_idx + 16'd1;
                r_base <= r_base + AW'(FRAME_WORDS);
              end
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign frame_o       = r_frame;
  assign frame_valid_o = r_frame_valid;
  assign frame_idx_o   = r_idx;
  assign last_frame_o  = r_last;
  assign table_ready_o = r_ready;
  assign wr_words_o    = r_wr_ptr;
  assign err_o         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_seq_table_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_seq_table_loader : randomized bench with a table-level reference model |
// | Rev 1.0                                                                    |
// +--------------------------------------------------------------------------+
module tb_seq_table_loader;

  localparam int FW    = 4;
  localparam int DEPTH = 1024;

  logic         clk_i = 1'b0;
  logic         reset_i = 1'b1;
  logic         trst_i = 1'b0;
  logic [31:0]  tdat_i = '0;
  logic         tdat_wstb_i = 1'b0;
  logic [15:0]  tlen_i = '0;
  logic         tlen_wstb_i = 1'b0;
  logic         start_i = 1'b0;
  logic         next_i = 1'b0;

  logic [32*FW-1:0] frame_o;
  logic             frame_valid_o;
  logic [15:0]      frame_idx_o;
  logic             last_frame_o;
  logic             table_ready_o;
  logic [10:0]      wr_words_o;
  logic             err_o;

  logic [32*FW-1:0] s_frame;
  logic             s_valid;
  logic [15:0]      s_idx;
  logic             s_last;
  logic             s_ready;
  logic [3:0]       s_wr_words;
  logic             s_err;

  seq_table_loader #(.FRAME_WORDS(FW), .DEPTH(DEPTH), .AW(10)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .trst_i(trst_i), .tdat_i(tdat_i),
    .tdat_wstb_i(tdat_wstb_i), .tlen_i(tlen_i), .tlen_wstb_i(tlen_wstb_i),
    .start_i(start_i), .next_i(next_i), .frame_o(frame_o),
    .frame_valid_o(frame_valid_o), .frame_idx_o(frame_idx_o),
    .last_frame_o(last_frame_o), .table_ready_o(table_ready_o),
    .wr_words_o(wr_words_o), .err_o(err_o)
  );

  // Small-depth instance shares stimulus; its outputs are only checked early
  seq_table_loader #(.FRAME_WORDS(FW), .DEPTH(8), .AW(3)) dut_small (
    .clk_i(clk_i), .reset_i(reset_i), .trst_i(trst_i), .tdat_i(tdat_i),
    .tdat_wstb_i(tdat_wstb_i), .tlen_i(tlen_i), .tlen_wstb_i(tlen_wstb_i),
    .start_i(start_i), .next_i(next_i), .frame_o(s_frame),
    .frame_valid_o(s_valid), .frame_idx_o(s_idx),
    .last_frame_o(s_last), .table_ready_o(s_ready),
    .wr_words_o(s_wr_words), .err_o(s_err)
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: table contents and register-level status
  logic [31:0] m_tab [DEPTH];
  int          m_wr, m_nfr, m_idx;
  bit          m_err, m_ready;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic m_write(input logic [31:0] d);
    if (m_ready || m_wr == DEPTH) m_err = 1;
    else begin
      m_tab[m_wr] = d;
      m_wr++;
    end
  endtask

  task automatic m_len(input int len);
    if (len != 0 && len % FW == 0 && len <= m_wr) begin
      m_nfr   = len / FW;
      m_ready = 1;
    end else begin
      m_ready = 0;
      m_err   = 1;
    end
  endtask

  task automatic do_trst();
    trst_i = 1; step(); trst_i = 0;
    m_wr = 0; m_err = 0; m_ready = 0; m_idx = 0;
  endtask

  task automatic wr_word(input logic [31:0] d, input bit with_len, input int len);
    tdat_i = d; tdat_wstb_i = 1;
    tlen_i = 16'(len); tlen_wstb_i = with_len;
    step();
    tdat_wstb_i = 0; tlen_wstb_i = 0;
    m_write(d);
    if (with_len) m_len(len);
  endtask

  task automatic wr_len(input int len);
    tlen_i = 16'(len); tlen_wstb_i = 1;
    step();
    tlen_wstb_i = 0;
    m_len(len);
  endtask

  task automatic chk_status(input string tag);
    chk({tag, "_wr_words"}, 64'(wr_words_o), 64'(m_wr));
    chk({tag, "_err"}, 64'(err_o), 64'(m_err));
    chk({tag, "_ready"}, 64'(table_ready_o), 64'(m_ready));
  endtask

  // Issue start or next from VALID (or start from IDLE) and check the frame
  task automatic play(input bit is_start, input bit disturb);
    int e;
    if (is_start) m_idx = 0;
    else m_idx = (m_idx == m_nfr - 1) ? 0 : m_idx + 1;
    start_i = is_start; next_i = ~is_start;
    step();
    start_i = 0; next_i = 0;
    e = 1;
    chk("valid_fall", 64'(frame_valid_o), 64'd0);
    if (disturb) begin
      next_i = 1; start_i = $urandom_range(0, 1);
      step();
      next_i = 0; start_i = 0;
      e++;
    end
    while (!frame_valid_o && e < 25) begin
      step();
      e++;
    end
    chk("latency", 64'(e), 64'(FW + 2));
    for (int k = 0; k < FW; k++)
      chk("frame_word", 64'(frame_o[32*k +: 32]), 64'(m_tab[m_idx*FW + k]));
    chk("frame_idx", 64'(frame_idx_o), 64'(m_idx));
    chk("last_frame", 64'(last_frame_o), 64'(m_idx == m_nfr - 1));
  endtask

  initial begin
    int n, len;
    logic [31:0] w;
    m_wr = 0; m_err = 0; m_ready = 0; m_nfr = 0; m_idx = 0;

    repeat (3) step();
    reset_i = 0;
    chk("rst_frame_lo", frame_o[63:0], 64'd0);
    chk("rst_frame_hi", frame_o[127:64], 64'd0);
    chk("rst_valid", 64'(frame_valid_o), 64'd0);
    chk("rst_idx", 64'(frame_idx_o), 64'd0);
    chk("rst_last", 64'(last_frame_o), 64'd0);
    chk_status("rst");

    // Overflow of the 8-deep instance; the deep one just takes 9 words
    for (int i = 0; i < 9; i++) wr_word($urandom, 0, 0);
    chk("small_wr_words", 64'(s_wr_words), 64'd8);
    chk("small_err", 64'(s_err), 64'd1);
    chk_status("deep9");
    wr_len(8);
    chk("small_ready", 64'(s_ready), 64'd1);
    play(1, 0);
    for (int k = 0; k < FW; k++) chk("small_f0", 64'(s_frame[32*k +: 32]), 64'(m_tab[k]));
    play(0, 0);
    for (int k = 0; k < FW; k++) chk("small_f1", 64'(s_frame[32*k +: 32]), 64'(m_tab[FW + k]));
    chk("small_last", 64'(s_last), 64'd1);
    chk("small_idx", 64'(s_idx), 64'd1);

    // Directed 0x10..0x17 table with wrap
    do_trst();
    for (int i = 0; i < 8; i++) wr_word(32'h10 + 32'(i), 0, 0);
    wr_len(8);
    chk_status("dir8");
    play(1, 0);
    play(0, 1);
    play(0, 0);

    // trst in the middle of a fetch
    next_i = 1; step(); next_i = 0;
    step();
    trst_i = 1; step(); trst_i = 0;
    m_wr = 0; m_err = 0; m_ready = 0; m_idx = 0;
    chk("trst_valid", 64'(frame_valid_o), 64'd0);
    chk_status("trst_mid");
    wr_word(32'hABCD, 0, 0);
    chk_status("after_trst");

    // Length not a frame multiple
    do_trst();
    for (int i = 0; i < 6; i++) wr_word($urandom, 0, 0);
    wr_len(6);
    chk_status("len6");
    start_i = 1; step(); start_i = 0;
    repeat (10) step();
    chk("len6_valid", 64'(frame_valid_o), 64'd0);

    // Length exceeds words written, then trst clears
    do_trst();
    for (int i = 0; i < 4; i++) wr_word($urandom, 0, 0);
    wr_len(8);
    chk_status("len_gt");
    do_trst();
    chk_status("len_gt_trst");

    // Same-cycle final write and length strobe
    for (int i = 0; i < 7; i++) wr_word($urandom, 0, 0);
    wr_word($urandom, 1, 8);
    chk_status("same_cyc");
    play(1, 0);

    // Randomized tables, lengths and playback sequences
    for (int it = 0; it < 14; it++) begin
      do_trst();
      n = $urandom_range(1, 40);
      if (n >= FW && $urandom_range(0, 3) != 0) len = FW * $urandom_range(1, n / FW);
      else len = $urandom_range(0, 44);
      for (int i = 0; i < n - 1; i++) wr_word($urandom, 0, 0);
      w = $urandom;
      if ($urandom_range(0, 1) == 1) wr_word(w, 1, len);
      else begin
        wr_word(w, 0, 0);
        wr_len(len);
      end
      chk_status("rnd_load");
      if (m_ready) begin
        play(1, $urandom_range(0, 1));
        for (int j = 0; j < 5; j++) play($urandom_range(0, 3) == 0, $urandom_range(0, 1));
        wr_word($urandom, 0, 0);
        chk_status("rnd_late_wr");
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seq_table_loader.md
Name: seq_table_loader

Overview:
Table store and frame prefetcher for the sequencer block. It sits between the register interface and the sequencer engine.
- Upstream side: TRST/TDAT/TLEN register strobes stream words into an internal block RAM.
- Downstream side: frames of FRAME_WORDS words are presented to the sequencer engine on demand.
- Playback wraps from the last frame back to frame 0 so the engine can repeat the table.

Parameters:
FRAME_WORDS, 4, 32-bit words per table frame
DEPTH, 1024, table capacity in words (power of two)
AW, 10, RAM address width, log2(DEPTH)

Ports:
clk_i  in  1  system clock; all logic is synchronous to the rising edge
reset_i  in  1  synchronous reset, active-high
trst_i  in  1  table reset strobe (TRST register write)
tdat_i  in  32  table data word
tdat_wstb_i  in  1  TDAT write strobe; appends tdat_i
tlen_i  in  16  table length in words
tlen_wstb_i  in  1  TLEN write strobe
start_i  in  1  begin playback from frame 0
next_i  in  1  advance to next frame
frame_o  out  32*FRAME_WORDS  current frame; word 0 in bits [31:0]
frame_valid_o  out  1  frame_o holds a complete, fetched frame
frame_idx_o  out  16  index of frame on frame_o
last_frame_o  out  1  frame_idx_o == nframes-1
table_ready_o  out  1  valid length accepted; playback permitted
wr_words_o  out  AW+1  words written since last TRST
err_o  out  1  sticky error; cleared only by TRST or reset

Behaviour:
- Reset (reset_i=1): all outputs 0; wr_ptr=0; FSM in IDLE. RAM contents are don't-care.
- trst_i: identical effect to reset_i, except RAM contents are untouched. It aborts any fetch in flight. It has priority over every other input in the same cycle.
- tdat_wstb_i:
  - When table_ready_o=0 and wr_ptr<DEPTH: write RAM[wr_ptr] and increment wr_ptr.
  - When wr_ptr==DEPTH: the word is dropped and err_o is set.
  - When table_ready_o=1: the word is dropped and err_o is set.
- tlen_wstb_i: the length is accepted when tlen_i!=0, tlen_i%FRAME_WORDS==0 and tlen_i<=wr_ptr.
  - On acceptance: nframes=tlen_i/FRAME_WORDS and table_ready_o=1 from the next cycle.
  - Otherwise: table_ready_o=0, err_o set, FSM forced to IDLE.
- Same-cycle tdat_wstb_i and tlen_wstb_i: the write is processed first, and the length check uses the incremented wr_ptr.
- FSM states: IDLE, FETCH, VALID.
  - IDLE: start_i with table_ready_o=1 -> FETCH, with idx=0. start_i with table_ready_o=0 is ignored.
  - FETCH: issues FRAME_WORDS consecutive reads at addresses idx*FRAME_WORDS+k, k=0..FRAME_WORDS-1, one per cycle. The RAM has 1-cycle read latency. Each returned word is captured into its slot of the frame register. frame_valid_o=0 throughout. After the final word is captured -> VALID.
  - VALID: frame_valid_o=1 and frame_idx_o=idx.
    - next_i: idx = (idx==nframes-1) ? 0 : idx+1, then -> FETCH.
    - start_i: idx=0, then -> FETCH. start_i has priority over next_i in the same cycle.
- Latency: a strobe in cycle N gives frame_valid_o=1 in cycle N+FRAME_WORDS+2 (cycle N+6 for the default parameters). frame_valid_o falls in cycle N+1.
- next_i or start_i during FETCH is ignored, with no queuing.
- frame_o holds its last value outside VALID and is never partially visible, because frame_valid_o gates its use.
- Wrap-around: nframes=1 gives repeated refetch of frame 0, with last_frame_o=1 permanently.
- last_frame_o is valid only while frame_valid_o=1; otherwise it is 0.

Decomposition:
- Shared package seq_pkg holds:
  - FRAME_WORDS
  - the state encoding (IDLE=0, FETCH=1, VALID=2)
  - the frame field offsets used by the sequencer engine (repeats, inputs/mask, phase1 time, phase2 time)
- One natural sub-module: seq_table_ram. It is a simple dual-port RAM, DEPTH x 32, with one write port, one registered read port and 1-cycle read latency, and infers BRAM.
- The FSM, write pointer and length check live in seq_table_loader.

Test Plan:
- Write 8 words 0x10..0x17, then tlen=8, then start_i.
  - Required: frame_valid_o rises 6 cycles after start_i; frame_o words are 0x10,0x11,0x12,0x13; frame_idx_o=0; last_frame_o=0.
- next_i twice from the frame 0 state above.
  - After the first next_i: frame 1 = 0x14..0x17 with last_frame_o=1.
  - After the second next_i: wrap to frame 0 = 0x10..0x13, with frame_idx_o=0.
- Write 6 words, then tlen=6.
  - Required: err_o=1, table_ready_o=0, and start_i leaves frame_valid_o=0.
- Write 4 words, then tlen=8 (length exceeds words written).
  - Required: err_o=1 and table_ready_o=0.
  - Then trst_i: err_o=0, wr_words_o=0.
- With DEPTH=8 (AW=3): write 9 words.
  - Required: wr_words_o=8 and err_o=1; RAM[0..7] hold the first 8 words.
- With a table loaded and playing:
  - Pulse next_i during FETCH: no effect on sequencing.
  - Pulse trst_i mid-FETCH: next cycle frame_valid_o=0, table_ready_o=0, FSM IDLE.
  - Then tdat writes are accepted again.
